// File: rtl/tdp_ram_param.sv
// tdp_ram_param: parametrised true dual-port synchronous RAM, single clock.
//   Two independent read/write ports (A, B) with a selectable same-port
//   read-during-write mode, optional second output register stage, per-port
//   read-valid flags and a same-address write collision pulse.
//
// Parameters:
//   DATA_W   - data width per word (1..64)
//   ADDR_W   - address width, depth = 2**ADDR_W
//   RDW_MODE - same-port read-during-write: 0 write-first, 1 read-first, 2 no-change
//   OUT_REG  - 1 adds an output register stage on both ports
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   en_x, we_x              - port enable, write enable (qualified by en_x)
//   addr_x, data_x          - word address, write data
//   q_x, vld_x              - read data, q_x updated by an accepted access
//   coll                    - one-cycle pulse after both ports wrote one address
//   coll_cnt                - saturating collision count, present only when
//                             TDP_RAM_COLLISION_CNT_EN is defined
module tdp_ram_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned RDW_MODE = 0,
    parameter int unsigned OUT_REG  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              en_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b,
    output logic              vld_a,
    output logic              vld_b,
    output logic              coll
`ifdef TDP_RAM_COLLISION_CNT_EN
    ,
    output logic [7:0]        coll_cnt
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_a_c;
    logic              wr_b_c;
    logic              wr_coll_c;
    logic [DATA_W-1:0] rd_a_c;
    logic [DATA_W-1:0] rd_b_c;
    logic [DATA_W:0]   nxt_a_c;
    logic [DATA_W:0]   nxt_b_c;

    logic [DATA_W-1:0] s1_q_a;
    logic [DATA_W-1:0] s1_q_b;
    logic              s1_v_a;
    logic              s1_v_b;
    logic              coll_q;

    // Stage-1 next value {valid, data} for one port.
    function automatic logic [DATA_W:0] stage1_next(
        input logic              en,
        input logic              we,
        input logic [DATA_W-1:0] rd,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] cur_q
    );
        logic [DATA_W:0] n;
        n = {1'b0, cur_q};
        if (en) begin
            if (!we) begin
                n = {1'b1, rd};
            end else begin
                case (RDW_MODE)
                    0:       n = {1'b1, wd};
                    1:       n = {1'b1, rd};
                    default: n = {1'b0, cur_q};
                endcase
            end
        end
        return n;
    endfunction

    assign wr_a_c    = en_a & we_a;
    assign wr_b_c    = en_b & we_b;
    assign wr_coll_c = wr_a_c & wr_b_c & (addr_a == addr_b);
    assign rd_a_c    = mem[addr_a];
    assign rd_b_c    = mem[addr_b];
    assign nxt_a_c   = stage1_next(en_a, we_a, rd_a_c, data_a, s1_q_a);
    assign nxt_b_c   = stage1_next(en_b, we_b, rd_b_c, data_b, s1_q_b);

    // Array write; port A wins a same-address collision, nothing lands in reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_b_c && !wr_coll_c) begin
                mem[addr_b] <= data_b;
            end
            if (wr_a_c) begin
                mem[addr_a] <= data_a;
            end
        end
    end

    // Stage-1 result registers and collision pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q_a <= '0;
            s1_q_b <= '0;
            s1_v_a <= 1'b0;
            s1_v_b <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            {s1_v_a, s1_q_a} <= nxt_a_c;
            {s1_v_b, s1_q_b} <= nxt_b_c;
            coll_q           <= wr_coll_c;
        end
    end

    assign coll = coll_q;

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] s2_q_a;
        logic [DATA_W-1:0] s2_q_b;
        logic              s2_v_a;
        logic              s2_v_b;

        // Stage 2 only loads on a valid stage-1 result so q holds between accesses.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_q_a <= '0;
                s2_q_b <= '0;
                s2_v_a <= 1'b0;
                s2_v_b <= 1'b0;
            end else begin
                if (s1_v_a) begin
                    s2_q_a <= s1_q_a;
                end
                if (s1_v_b) begin
                    s2_q_b <= s1_q_b;
                end
                s2_v_a <= s1_v_a;
                s2_v_b <= s1_v_b;
            end
        end

        assign q_a   = s2_q_a;
        assign q_b   = s2_q_b;
        assign vld_a = s2_v_a;
        assign vld_b = s2_v_b;
    end else begin : g_no_out_reg
        assign q_a   = s1_q_a;
        assign q_b   = s1_q_b;
        assign vld_a = s1_v_a;
        assign vld_b = s1_v_b;
    end

`ifdef TDP_RAM_COLLISION_CNT_EN
    // Saturating count of collision pulses, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt <= '0;
        end else if (coll_q && (coll_cnt != {CNT_W{1'b1}})) begin
            coll_cnt <= coll_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tdp_ram_param.sv
// Bench for tdp_ram_param: four instances share stimulus (write-first,
// read-first, no-change, and write-first with output register), all 32x1024.
module tb_tdp_ram_param;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned NI    = 4;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned MODE_T [NI] = '{0, 1, 2, 0};
    localparam int unsigned OREG_T [NI] = '{0, 0, 0, 1};

    typedef struct packed {
        logic [DW-1:0] q;
        logic          k;   // q value is known to the model
        logic          v;
    } port_t;

    typedef struct packed {
        port_t a;
        port_t b;
        logic  coll;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          en_a, en_b, we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;

    logic [DW-1:0] q_a_w   [NI];
    logic [DW-1:0] q_b_w   [NI];
    logic          vld_a_w [NI];
    logic          vld_b_w [NI];
    logic          coll_w  [NI];
`ifdef TDP_RAM_COLLISION_CNT_EN
    logic [7:0]    cnt_w   [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
        tdp_ram_param #(
            .DATA_W  (DW),
            .ADDR_W  (AW),
            .RDW_MODE(MODE_T[g]),
            .OUT_REG (OREG_T[g])
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_a    (en_a),
            .en_b    (en_b),
            .we_a    (we_a),
            .we_b    (we_b),
            .addr_a  (addr_a),
            .addr_b  (addr_b),
            .data_a  (data_a),
            .data_b  (data_b),
            .q_a     (q_a_w[g]),
            .q_b     (q_b_w[g]),
            .vld_a   (vld_a_w[g]),
            .vld_b   (vld_b_w[g]),
            .coll    (coll_w[g])
`ifdef TDP_RAM_COLLISION_CNT_EN
            ,
            .coll_cnt(cnt_w[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mram   [DEPTH];
    logic          mknown [DEPTH];
    port_t         s1a [NI];
    port_t         s1b [NI];
    port_t         s2a [NI];
    port_t         s2b [NI];
    logic          mcoll;
    int unsigned   mcnt;
    exp_t          sb [$];
    exp_t          chk_e;
    int            n_vec;
    int            n_err;

    function automatic port_t p1_next(input port_t cur, input logic en, input logic we,
                                      input logic [AW-1:0] addr, input logic [DW-1:0] d,
                                      input int unsigned mode);
        port_t n;
        n = cur;
        if (!en) begin
            n.v = 1'b0;
        end else if (!we || mode == 1) begin
            n.q = mram[addr];
            n.k = mknown[addr];
            n.v = 1'b1;
        end else if (mode == 0) begin
            n.q = d;
            n.k = 1'b1;
            n.v = 1'b1;
        end else begin
            n.v = 1'b0;
        end
        return n;
    endfunction

    function automatic port_t p2_next(input port_t cur2, input port_t s1);
        port_t n;
        n = s1.v ? s1 : cur2;
        n.v = s1.v;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            s1a[i] = port_t'{q: '0, k: 1'b1, v: 1'b0};
            s1b[i] = port_t'{q: '0, k: 1'b1, v: 1'b0};
            s2a[i] = port_t'{q: '0, k: 1'b1, v: 1'b0};
            s2b[i] = port_t'{q: '0, k: 1'b1, v: 1'b0};
        end
        mcoll = 1'b0;
        mcnt  = 0;
    endtask

    // Drive one cycle, advance the model, queue the expected outputs.
    task automatic tick(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        exp_t e;
        en_a = ea; we_a = wa; addr_a = aa; data_a = da;
        en_b = eb; we_b = wb; addr_b = ab; data_b = db;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (OREG_T[i] != 0) begin
                    s2a[i] = p2_next(s2a[i], s1a[i]);
                    s2b[i] = p2_next(s2b[i], s1b[i]);
                end
                s1a[i] = p1_next(s1a[i], ea, wa, aa, da, MODE_T[i]);
                s1b[i] = p1_next(s1b[i], eb, wb, ab, db, MODE_T[i]);
            end
            if (mcoll && mcnt < 255) mcnt++;
            mcoll = ea & wa & eb & wb & (aa == ab);
            if (eb && wb) begin mram[ab] = db; mknown[ab] = 1'b1; end
            if (ea && wa) begin mram[aa] = da; mknown[aa] = 1'b1; end
        end
        for (int i = 0; i < NI; i++) begin
            e.a    = (OREG_T[i] != 0) ? s2a[i] : s1a[i];
            e.b    = (OREG_T[i] != 0) ? s2b[i] : s1b[i];
            e.coll = mcoll;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Scoreboard: one entry per instance per driven edge
    always @(posedge clk) begin
        #1;
        if (sb.size() >= NI) begin
            for (int i = 0; i < NI; i++) begin
                chk_e = sb.pop_front();
                n_vec++;
                if (vld_a_w[i] !== chk_e.a.v) begin
                    n_err++;
                    $display("FAIL sb_vld_a inst%0d t=%0t got %0b want %0b", i, $time, vld_a_w[i], chk_e.a.v);
                end
                n_vec++;
                if (vld_b_w[i] !== chk_e.b.v) begin
                    n_err++;
                    $display("FAIL sb_vld_b inst%0d t=%0t got %0b want %0b", i, $time, vld_b_w[i], chk_e.b.v);
                end
                n_vec++;
                if (coll_w[i] !== chk_e.coll) begin
                    n_err++;
                    $display("FAIL sb_coll inst%0d t=%0t got %0b want %0b", i, $time, coll_w[i], chk_e.coll);
                end
                if (chk_e.a.k) begin
                    n_vec++;
                    if (q_a_w[i] !== chk_e.a.q) begin
                        n_err++;
                        $display("FAIL sb_q_a inst%0d t=%0t got %0h want %0h", i, $time, q_a_w[i], chk_e.a.q);
                    end
                end
                if (chk_e.b.k) begin
                    n_vec++;
                    if (q_b_w[i] !== chk_e.b.q) begin
                        n_err++;
                        $display("FAIL sb_q_b inst%0d t=%0t got %0h want %0h", i, $time, q_b_w[i], chk_e.b.q);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        idle();
        idle();
        #3 rst_n = 1'b1;
        tick(1, 1, AW'(5), DW'(32'h33), 0, 0, '0, '0);
        idle();
        // assert reset mid-cycle: outputs clear without a clock edge
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ({q_a_w[i], q_b_w[i], vld_a_w[i], vld_b_w[i], coll_w[i]} !== '0) begin
                n_err++;
                $display("FAIL reset_async inst%0d got q_a=%0h q_b=%0h vld=%0b%0b coll=%0b want all 0",
                         i, q_a_w[i], q_b_w[i], vld_a_w[i], vld_b_w[i], coll_w[i]);
            end
        end
        #1;
        tick(1, 1, AW'(5), DW'(32'hEE), 0, 0, '0, '0);
        tick(1, 1, AW'(5), DW'(32'hEE), 0, 0, '0, '0);
        #3 rst_n = 1'b1;
        tick(1, 0, AW'(5), '0, 0, 0, '0, '0);
        n_vec++;
        if (q_a_w[0] !== DW'(32'h33)) begin
            n_err++;
            $display("FAIL reset_write_ignored got %0h want 33", q_a_w[0]);
        end
        idle();
    endtask

    task automatic test_basic();
        tick(1, 1, AW'(10'h10), DW'(32'hA5), 0, 0, '0, '0);
        tick(0, 0, '0, '0, 1, 0, AW'(10'h10), '0);
        n_vec++;
        if (q_b_w[0] !== DW'(32'hA5) || vld_b_w[0] !== 1'b1) begin
            n_err++;
            $display("FAIL basic_oreg0 got q_b=%0h vld_b=%0b want A5/1", q_b_w[0], vld_b_w[0]);
        end
        n_vec++;
        if (vld_b_w[3] !== 1'b0) begin
            n_err++;
            $display("FAIL basic_oreg1_early got vld_b=%0b want 0", vld_b_w[3]);
        end
        idle();
        n_vec++;
        if (q_b_w[3] !== DW'(32'hA5) || vld_b_w[3] !== 1'b1) begin
            n_err++;
            $display("FAIL basic_oreg1 got q_b=%0h vld_b=%0b want A5/1", q_b_w[3], vld_b_w[3]);
        end
        idle();
    endtask

    task automatic test_rdw();
        tick(1, 1, AW'(10'h3F), DW'(32'h11), 0, 0, '0, '0);
        tick(1, 0, AW'(10'h3F), '0, 0, 0, '0, '0);
        tick(1, 1, AW'(10'h3F), DW'(32'h22), 0, 0, '0, '0);
        n_vec++;
        if (q_a_w[0] !== DW'(32'h22) || vld_a_w[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rdw_write_first got %0h/%0b want 22/1", q_a_w[0], vld_a_w[0]);
        end
        n_vec++;
        if (q_a_w[1] !== DW'(32'h11) || vld_a_w[1] !== 1'b1) begin
            n_err++;
            $display("FAIL rdw_read_first got %0h/%0b want 11/1", q_a_w[1], vld_a_w[1]);
        end
        n_vec++;
        if (q_a_w[2] !== DW'(32'h11) || vld_a_w[2] !== 1'b0) begin
            n_err++;
            $display("FAIL rdw_no_change got %0h/%0b want 11/0", q_a_w[2], vld_a_w[2]);
        end
        idle();
        n_vec++;
        if (q_a_w[3] !== DW'(32'h22)) begin
            n_err++;
            $display("FAIL rdw_write_first_oreg got %0h want 22", q_a_w[3]);
        end
    endtask

    task automatic test_cross();
        tick(1, 1, '0, '0, 0, 0, '0, '0);
        tick(1, 1, '0, DW'(32'h5A), 1, 0, '0, '0);
        n_vec++;
        if (q_b_w[0] !== '0) begin
            n_err++;
            $display("FAIL cross_old_data got %0h want 0", q_b_w[0]);
        end
        tick(0, 0, '0, '0, 1, 0, '0, '0);
        n_vec++;
        if (q_b_w[0] !== DW'(32'h5A)) begin
            n_err++;
            $display("FAIL cross_new_data got %0h want 5A", q_b_w[0]);
        end
        idle();
    endtask

    task automatic test_collision();
        tick(1, 1, AW'(10'h20), DW'(32'h01), 1, 1, AW'(10'h20), DW'(32'h02));
        n_vec++;
        if (coll_w[0] !== 1'b1 || q_a_w[0] !== DW'(32'h01) || q_b_w[0] !== DW'(32'h02)) begin
            n_err++;
            $display("FAIL coll_pulse got coll=%0b q_a=%0h q_b=%0h want 1/01/02", coll_w[0], q_a_w[0], q_b_w[0]);
        end
        idle();
        n_vec++;
        if (coll_w[3] !== 1'b0) begin
            n_err++;
            $display("FAIL coll_one_cycle got %0b want 0", coll_w[3]);
        end
        tick(0, 0, '0, '0, 1, 0, AW'(10'h20), '0);
        n_vec++;
        if (q_b_w[0] !== DW'(32'h01)) begin
            n_err++;
            $display("FAIL coll_a_wins got %0h want 01", q_b_w[0]);
        end
        idle();
    endtask

    task automatic test_sweep();
        for (int k = 0; k < int'(DEPTH); k++) begin
            tick(1, 1, AW'(k), DW'(k), 0, 0, '0, '0);
        end
        // read back starting mid-array so the 0x3FF -> 0x000 wrap is back-to-back
        for (int j = 0; j < int'(DEPTH); j++) begin
            int unsigned a;
            a = (j + 512) % DEPTH;
            tick(0, 0, '0, '0, 1, 0, AW'(a), '0);
            n_vec++;
            if (q_b_w[0] !== DW'(a) || vld_b_w[0] !== 1'b1) begin
                n_err++;
                $display("FAIL sweep addr %0h got %0h/%0b want %0h/1", a, q_b_w[0], vld_b_w[0], a);
            end
        end
        idle();
        idle();
    endtask

`ifdef TDP_RAM_COLLISION_CNT_EN
    task automatic test_coll_cnt();
        for (int k = 0; k < 300; k++) begin
            tick(1, 1, AW'(10'h20), DW'(k), 1, 1, AW'(10'h20), '0);
        end
        idle();
        idle();
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (cnt_w[i] !== 8'd255) begin
                n_err++;
                $display("FAIL coll_cnt_sat inst%0d got %0d want 255", i, cnt_w[i]);
            end
        end
    endtask
`endif

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        en_a   = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0;   addr_b = '0; data_a = '0; data_b = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mram[i]   = '0;
            mknown[i] = 1'b0;
        end
        model_reset();
        #2;
        test_reset();
        test_basic();
        test_rdw();
        test_cross();
        test_collision();
        test_sweep();
`ifdef TDP_RAM_COLLISION_CNT_EN
        test_coll_cnt();
`endif
        repeat (2) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
